alu_seq_control: RTL and testbench
==================================

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, execute cycles for MUL (legal range 1..31).
REQ-002 SHALL have parameter DIV_LAT, default 16, execute cycles for UDIV/SDIV (legal range 1..31).
REQ-003 SHALL have parameter CNT_W, default 5, down-counter width; 2^CNT_W SHALL exceed max(MUL_LAT, DIV_LAT).
REQ-004 SHALL have port clk, input, 1, the single clock, all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, a decode request is present.
REQ-007 SHALL have port alu_op, input, 2, main-decoder class: 00 load/store, 01 CBZ, 10 R-type, 11 reserved.
REQ-008 SHALL have port opcode, input, 11, instruction bits [31:21].
REQ-009 SHALL have port ready, output, 1, the block accepts a request this cycle.
REQ-010 SHALL have port alu_control, output, 4, registered ALU operation code.
REQ-011 SHALL have port valid_out, output, 1, a one-cycle pulse meaning alu_control/illegal are final for the accepted request.
REQ-012 SHALL have port busy, output, 1, a multi-cycle operation is in progress.
REQ-013 SHALL have port illegal, output, 1, the accepted request was undecodable; registered alongside valid_out.

Function
REQ-014 A request SHALL be accepted when valid_in=1 and ready=1 at a rising edge; otherwise inputs SHALL be ignored.
REQ-015 Decode SHALL map alu_op 00 to 0010 (ADD) and alu_op 01 to 0111 (pass B).
REQ-016 Decode for alu_op 10 SHALL map opcode 10001011000 to 0010, 11001011000 to 0110, 10001010000 to 0000, 10101010000 to 0001, 10011011000 to 1000 (MUL), and 10011010110 to 1001 (DIV).
REQ-017 alu_op 11, or alu_op 10 with any other opcode, SHALL produce alu_control 1111 with illegal=1, treated as a single-cycle op.
REQ-018 The FSM SHALL have two states, IDLE and BUSY; ready SHALL equal (state==IDLE).
REQ-019 In IDLE, an accepted single-cycle op SHALL register alu_control/illegal and assert valid_out on the next cycle (latency 1), remaining in IDLE, so back-to-back single-cycle ops SHALL give valid_out every cycle.
REQ-020 In IDLE, an accepted MUL or DIV with LAT>1 SHALL register alu_control, load the counter with LAT-2, and move to BUSY.
REQ-021 In IDLE, an accepted MUL or DIV with LAT=1 SHALL behave exactly as a single-cycle op.
REQ-022 In BUSY: busy=1, ready=0; alu_control SHALL hold and valid_in SHALL be ignored.
REQ-023 In BUSY, the counter SHALL decrement each cycle; at count 0, valid_out SHALL pulse on the next cycle and the state SHALL return to IDLE at the same edge.
REQ-024 Total latency SHALL be: an op accepted at edge N gives valid_out high in the cycle following edge N+LAT-1, i.e. LAT cycles after acceptance.
REQ-025 ready SHALL reassert in the same cycle valid_out pulses for a multi-cycle op, so a new request SHALL be acceptable at that edge.
REQ-026 valid_out SHALL be exactly one cycle per accepted request; alu_control SHALL hold its value until the next acceptance.
REQ-027 busy SHALL be deasserted in IDLE.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, alu_control=0000, valid_out=0, busy=0, illegal=0, ready=1.
REQ-029 Reset asserted during BUSY SHALL abort the operation with no valid_out pulse; after deassertion the first edge with valid_in=1 SHALL be accepted.
REQ-030 All outputs SHALL be defined (no X) from reset onward.

Verification
REQ-031 Reset then three back-to-back requests (ADD 10001011000, SUB 11001011000, ORR 10101010000, alu_op=10) -> valid_out high for 3 consecutive cycles with alu_control 0010, 0110, 0001; ready stays 1.
REQ-032 MUL request (opcode 10011011000, MUL_LAT=4) -> alu_control=1000, busy=1/ready=0 for 3 cycles, then valid_out pulses 4 cycles after acceptance; a SUB held on valid_in throughout is accepted only when ready=1.
REQ-033 DIV request with DIV_LAT=16 immediately followed by an AND -> DIV valid_out at +16 with 1001, then AND valid_out one cycle later with 0000.
REQ-034 alu_op=11 and alu_op=10 with opcode 11111111111 -> each gives valid_out with alu_control=1111 and illegal=1 at latency 1.
REQ-035 reset pulsed mid-DIV (cycle 5 of 16) -> outputs reach reset values without a clock edge, no valid_out, and the next ADD completes at latency 1.
REQ-036 Rebuild with MUL_LAT=1 -> MUL completes at latency 1 and busy is never asserted.

Source files
------------

// File: rtl/alu_seq_control.sv
// ---------------------------------------------------------------------------
// alu_seq_control
//
// ALU control decoder with a sequencer for multi-cycle operations. Single-cycle
// operations complete one cycle after acceptance; MUL and DIV hold the block
// busy so that valid_out arrives exactly MUL_LAT / DIV_LAT cycles after the
// request was accepted.
//
// Parameters
//   MUL_LAT  execute cycles for MUL       (1..31)
//   DIV_LAT  execute cycles for UDIV/SDIV (1..31)
//   CNT_W    down-counter width, 2**CNT_W must exceed max(MUL_LAT, DIV_LAT)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   valid_in     in   decode request present
//   alu_op[1:0]  in   main decoder class (00 ld/st, 01 CBZ, 10 R-type, 11 rsvd)
//   opcode[10:0] in   instruction bits [31:21]
//   ready        out  request is accepted at the next rising edge if valid_in
//   alu_control  out  registered ALU operation, held until the next acceptance
//   valid_out    out  one-cycle pulse: alu_control/illegal are final
//   busy         out  a multi-cycle operation is in progress
//   illegal      out  accepted request was undecodable
// ---------------------------------------------------------------------------
module alu_seq_control #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic        ready,
  output logic [3:0]  alu_control,
  output logic        valid_out,
  output logic        busy,
  output logic        illegal
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_ORR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b0111;
  localparam logic [3:0] CTRL_MUL  = 4'b1000;
  localparam logic [3:0] CTRL_DIV  = 4'b1001;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  // The counter is loaded with LAT-2: one cycle is spent on the accepting
  // edge and one on the edge that leaves BUSY, so BUSY lasts LAT-1 cycles.
  // The load values are only used when the matching latency exceeds 1.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
  localparam bit MUL_MULTI = (MUL_LAT > 1);
  localparam bit DIV_MULTI = (DIV_LAT > 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       ctrl_q,  ctrl_d;
  logic             vld_q,   vld_d;
  logic             ill_q,   ill_d;

  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       dec_mul;
  logic       dec_div;

  // Decoder: anything not explicitly listed becomes an illegal single-cycle op.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    dec_ctrl = CTRL_ILL;
    dec_ill  = 1'b1;
    unique case (alu_op)
      2'b00: begin
        dec_ctrl = CTRL_ADD;
        dec_ill  = 1'b0;
      end
      2'b01: begin
        dec_ctrl = CTRL_PASS;
        dec_ill  = 1'b0;
      end
      2'b10: begin
        dec_ill = 1'b0;
        case (opcode)
          11'b10001011000: dec_ctrl = CTRL_ADD;
          11'b11001011000: dec_ctrl = CTRL_SUB;
          11'b10001010000: dec_ctrl = CTRL_AND;
          11'b10101010000: dec_ctrl = CTRL_ORR;
          11'b10011011000: dec_ctrl = CTRL_MUL;
          11'b10011010110: dec_ctrl = CTRL_DIV;
          default: begin
            dec_ctrl = CTRL_ILL;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl = CTRL_ILL;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign dec_mul = (alu_op == 2'b10) && (opcode == 11'b10011011000);
  assign dec_div = (alu_op == 2'b10) && (opcode == 11'b10011010110);

  // Next-state logic. valid_in is only looked at in IDLE, which is exactly
  // when ready is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          ctrl_d = dec_ctrl;
          ill_d  = dec_ill;
          if (dec_mul && MUL_MULTI) begin
            cnt_d   = MUL_LOAD;
            state_d = S_BUSY;
          end else if (dec_div && DIV_MULTI) begin
            cnt_d   = DIV_LOAD;
            state_d = S_BUSY;
          end else begin
            // Single-cycle op (including latency-1 MUL/DIV): result next cycle.
            vld_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 4'b0000;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign busy        = (state_q == S_BUSY);
  assign alu_control = ctrl_q;
  assign valid_out   = vld_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_seq_control.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_control
//
// Two instances share one stimulus stream: dut0 with default latencies
// (MUL 4, DIV 16) and dut1 with MUL_LAT=1. A reference model tracks, per
// instance, the edge at which the last accepted request completes and the
// first edge at which a new request may be accepted, and derives the expected
// ready/busy/valid_out/alu_control/illegal from those two numbers.
// ---------------------------------------------------------------------------
module tb_alu_seq_control;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;
  localparam logic [10:0] OP_DIV = 11'b10011010110;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [1:0]  alu_op;
  logic [10:0] opcode;

  logic       ready0, valid0, busy0, ill0;
  logic [3:0] ctrl0;
  logic       ready1, valid1, busy1, ill1;
  logic [3:0] ctrl1;

  always #5 clk = ~clk;

  alu_seq_control dut0 (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .alu_op     (alu_op),
    .opcode     (opcode),
    .ready      (ready0),
    .alu_control(ctrl0),
    .valid_out  (valid0),
    .busy       (busy0),
    .illegal    (ill0)
  );

  alu_seq_control #(.MUL_LAT(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .alu_op     (alu_op),
    .opcode     (opcode),
    .ready      (ready1),
    .alu_control(ctrl1),
    .valid_out  (valid1),
    .busy       (busy1),
    .illegal    (ill1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, index 0 = dut0, 1 = dut1.
  int         mul_lat  [2] = '{4, 1};
  int         div_lat  [2] = '{16, 16};
  int         done_edge[2];
  int         ready_at [2];
  logic [3:0] exp_ctrl [2];
  logic       exp_ill  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  // Spec decode table: kind 0 = single-cycle, 1 = MUL, 2 = DIV.
  task automatic spec_decode(input logic [1:0] op, input logic [10:0] opc,
                             output logic [3:0] c, output logic ill, output int kind);
    kind = 0;
    ill  = 1'b0;
    if (op == 2'b00)      c = 4'b0010;
    else if (op == 2'b01) c = 4'b0111;
    else if (op == 2'b11) begin c = 4'b1111; ill = 1'b1; end
    else if (opc == OP_ADD) c = 4'b0010;
    else if (opc == OP_SUB) c = 4'b0110;
    else if (opc == OP_AND) c = 4'b0000;
    else if (opc == OP_ORR) c = 4'b0001;
    else if (opc == OP_MUL) begin c = 4'b1000; kind = 1; end
    else if (opc == OP_DIV) begin c = 4'b1001; kind = 2; end
    else begin c = 4'b1111; ill = 1'b1; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      done_edge[k] = -1;
      ready_at[k]  = 0;
      exp_ctrl[k]  = 4'b0000;
      exp_ill[k]   = 1'b0;
    end
  endtask

  // Called just before rising edge number c with inputs already stable.
  task automatic model_edge(input int c);
    logic [3:0] dc;
    logic       di;
    int         kind;
    int         lat;
    spec_decode(alu_op, opcode, dc, di, kind);
    for (int k = 0; k < 2; k++) begin
      if (valid_in && c >= ready_at[k]) begin
        lat = (kind == 1) ? mul_lat[k] : (kind == 2) ? div_lat[k] : 1;
        exp_ctrl[k]  = dc;
        exp_ill[k]   = di;
        done_edge[k] = c + lat - 1;
        ready_at[k]  = c + lat;
      end
    end
  endtask

  // Called between edges e and e+1.
  task automatic check_outputs(input int e);
    logic       g_ready, g_valid, g_busy, g_ill;
    logic [3:0] g_ctrl;
    logic       x_busy, x_valid;
    for (int k = 0; k < 2; k++) begin
      g_ready = (k == 0) ? ready0 : ready1;
      g_valid = (k == 0) ? valid0 : valid1;
      g_busy  = (k == 0) ? busy0  : busy1;
      g_ill   = (k == 0) ? ill0   : ill1;
      g_ctrl  = (k == 0) ? ctrl0  : ctrl1;
      x_busy  = (done_edge[k] > e);
      x_valid = (done_edge[k] == e);
      check($sformatf("d%0d_ready", k), 32'(g_ready), 32'(!x_busy));
      check($sformatf("d%0d_busy", k),  32'(g_busy),  32'(x_busy));
      check($sformatf("d%0d_valid", k), 32'(g_valid), 32'(x_valid));
      check($sformatf("d%0d_ctrl", k),  32'(g_ctrl),  32'(exp_ctrl[k]));
      if (x_valid) check($sformatf("d%0d_illegal", k), 32'(g_ill), 32'(exp_ill[k]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_d0_ready"}, 32'(ready0), 32'd1);
    check({tag, "_d0_ctrl"},  32'(ctrl0),  32'd0);
    check({tag, "_d0_valid"}, 32'(valid0), 32'd0);
    check({tag, "_d0_busy"},  32'(busy0),  32'd0);
    check({tag, "_d0_ill"},   32'(ill0),   32'd0);
    check({tag, "_d1_ready"}, 32'(ready1), 32'd1);
    check({tag, "_d1_ctrl"},  32'(ctrl1),  32'd0);
    check({tag, "_d1_valid"}, 32'(valid1), 32'd0);
    check({tag, "_d1_busy"},  32'(busy1),  32'd0);
    check({tag, "_d1_ill"},   32'(ill1),   32'd0);
  endtask

  // One clock cycle: drive inputs, predict, take the edge, check mid-cycle.
  task automatic step(input logic v, input logic [1:0] op, input logic [10:0] opc);
    valid_in = v;
    alu_op   = op;
    opcode   = opc;
    model_edge(cyc);
    @(posedge clk);
    @(negedge clk);
    check_outputs(cyc);
    cyc++;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  logic [10:0] rnd_ops [6] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL, OP_DIV};

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    alu_op   = 2'b00;
    opcode   = '0;
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Back-to-back single-cycle R-type ops.
    step(1'b1, 2'b10, OP_ADD);
    step(1'b1, 2'b10, OP_SUB);
    step(1'b1, 2'b10, OP_ORR);
    step(1'b0, 2'b00, '0);

    // MUL with a SUB held on valid_in until it is accepted.
    step(1'b1, 2'b10, OP_MUL);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, OP_SUB);
    step(1'b0, 2'b00, '0);

    // DIV immediately followed by a held AND.
    step(1'b1, 2'b10, OP_DIV);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b10, OP_AND);
    step(1'b0, 2'b00, '0);

    // Illegal requests, plus load/store and CBZ classes.
    step(1'b1, 2'b11, OP_ADD);
    step(1'b1, 2'b10, 11'h7FF);
    step(1'b1, 2'b00, 11'h123);
    step(1'b1, 2'b01, 11'h456);
    step(1'b0, 2'b00, '0);

    // Reset in the middle of a DIV, then an ADD at latency 1.
    step(1'b1, 2'b10, OP_DIV);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, '0);
    pulse_reset("mid_div");
    step(1'b1, 2'b10, OP_ADD);
    step(1'b0, 2'b00, '0);

    // MUL on both: dut1 completes at latency 1, dut0 at 4.
    step(1'b1, 2'b10, OP_MUL);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, '0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        v;
      logic [1:0]  op;
      logic [10:0] opc;
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      opc = ($urandom_range(0, 4) == 0) ? 11'($urandom) : rnd_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd");
      step(v, op, opc);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 2'b00, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
